// File: rtl/vga_capture.sv
// Receive side of the VGA loopback: recovers line/frame timing from the sync edges,
// validates it against the nominal totals and emits visible pixels tagged with (x,y).
module vga_capture #(
  parameter int RGB_W    = 12,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int H_START  = 144,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int V_START  = 34,
  parameter int X_W      = 10,
  parameter int Y_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             h_sync,
  input  logic             v_sync,
  input  logic [RGB_W-1:0] pixel_in,
  output logic             pix_valid,
  output logic [RGB_W-1:0] pix_data,
  output logic [X_W-1:0]   pix_x,
  output logic [Y_W-1:0]   pix_y,
  output logic             frame_start,
  output logic             locked,
  output logic             sync_err,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {SEARCH, ARM, TRACK, LOCKED} state_t;

  localparam logic [X_W-1:0] H_LAST = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_LO   = X_W'(H_START);
  localparam logic [X_W-1:0] H_HI   = X_W'(H_START + H_ACTIVE);
  localparam logic [Y_W-1:0] V_LAST = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_LO   = Y_W'(V_START);
  localparam logic [Y_W-1:0] V_HI   = Y_W'(V_START + V_ACTIVE);

  state_t         state, next_state;
  logic           h_d, v_d;
  logic           hfall, vfall;
  logic           vfall_pend;
  logic           checking;
  logic           timing_err;
  logic           in_window;
  logic [X_W-1:0] h_cnt;
  logic [Y_W-1:0] v_cnt;

  assign hfall     = !h_sync & h_d;
  assign vfall     = !v_sync & v_d;
  assign checking  = (state == TRACK) || (state == LOCKED);
  assign in_window = (h_cnt >= H_LO) && (h_cnt < H_HI) &&
                     (v_cnt >= V_LO) && (v_cnt < V_HI);

  // A vfall coinciding with an hfall belongs to the line that hfall ends,
  // so it both satisfies that line's check and zeroes v_cnt on the same edge.
  always_comb begin
    timing_err = 1'b0;
    next_state = state;
    if (checking) begin
      if (hfall && (h_cnt != H_LAST))
        timing_err = 1'b1;
      if (!hfall && (h_cnt == H_LAST))
        timing_err = 1'b1;
      if (vfall && (v_cnt != V_LAST))
        timing_err = 1'b1;
      if (hfall && (v_cnt == V_LAST) && !vfall_pend && !vfall)
        timing_err = 1'b1;
    end
    case (state)
      SEARCH: if (vfall) next_state = ARM;
      ARM:    if (hfall) next_state = TRACK;
      TRACK: begin
        if (timing_err)
          next_state = SEARCH;
        else if (vfall)
          next_state = LOCKED;
      end
      LOCKED: if (timing_err) next_state = SEARCH;
      default: next_state = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEARCH;
      h_d        <= 1'b1;
      v_d        <= 1'b1;
      h_cnt      <= '0;
      v_cnt      <= '0;
      vfall_pend <= 1'b0;
    end else begin
      state <= next_state;
      h_d   <= h_sync;
      v_d   <= v_sync;
      h_cnt <= hfall ? '0 : h_cnt + 1'b1;
      if (hfall) begin
        if ((state == ARM) || (checking && (vfall_pend || vfall)))
          v_cnt <= '0;
        else
          v_cnt <= v_cnt + 1'b1;
        vfall_pend <= 1'b0;
      end else if (checking && vfall && !timing_err) begin
        vfall_pend <= 1'b1;
      end
    end
  end

  // Output stage: one cycle behind the sampled inputs; data/x/y hold between pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      err_cnt     <= '0;
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= timing_err;
      locked      <= (next_state == LOCKED);
      if (timing_err && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
      if ((state == LOCKED) && !timing_err && in_window) begin
        pix_valid   <= 1'b1;
        pix_data    <= pixel_in;
        pix_x       <= h_cnt - H_LO;
        pix_y       <= v_cnt - V_LO;
        frame_start <= (h_cnt == H_LO) && (v_cnt == V_LO);
      end
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using a shrunk raster (40x20 clocks, 16x8 visible)
// driven by an in-bench sync/pixel generator.
module tb_vga_capture;

  localparam int RGB_W    = 12;
  localparam int H_ACTIVE = 16;
  localparam int H_TOTAL  = 40;
  localparam int H_START  = 10;
  localparam int V_ACTIVE = 8;
  localparam int V_TOTAL  = 20;
  localparam int V_START  = 5;
  localparam int X_W      = 10;
  localparam int Y_W      = 10;
  localparam int HS_W     = 4;
  localparam int VS_X     = 20;
  localparam int FRAME    = H_TOTAL * V_TOTAL;
  // Receiver h_cnt lags the generator column by one clock, so visible
  // column 0 is generator column H_START+1.
  localparam int GX0      = H_START + 1;
  localparam int GY0      = V_START;

  logic             clk, rst, h_sync, v_sync;
  logic [RGB_W-1:0] pixel_in;
  logic             pix_valid, frame_start, locked, sync_err;
  logic [RGB_W-1:0] pix_data;
  logic [X_W-1:0]   pix_x;
  logic [Y_W-1:0]   pix_y;
  logic [7:0]       err_cnt;

  int compared, mismatched;
  int gx, gy, line_len, pgx, pgy, obs_gx, obs_gy;
  int err_pulses, valid_seen, frame_pix, frame_fs;
  bit hold_high, inj_v, manual, chk_pix, found;

  vga_capture #(
    .RGB_W(RGB_W), .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL), .H_START(H_START),
    .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL), .V_START(V_START), .X_W(X_W), .Y_W(Y_W)
  ) dut (
    .clk(clk), .rst(rst), .h_sync(h_sync), .v_sync(v_sync), .pixel_in(pixel_in),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .locked(locked), .sync_err(sync_err), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [11:0] pat(input int x, input int y);
    logic [5:0] xs, ys;
    xs = x[5:0];
    ys = y[5:0];
    return {ys, xs} ^ 12'hA5A;
  endfunction

  // v_sync is low from mid-way through the last line to mid-way through line 1.
  function automatic bit v_low(input int x, input int y);
    return (y == V_TOTAL - 1 && x >= VS_X) || (y == 0) || (y == 1 && x < VS_X);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Observe outputs produced by the edge that sampled generator column pgx/pgy.
  task automatic sample();
    bit exp_v;
    obs_gx = pgx;
    obs_gy = pgy;
    if (sync_err) err_pulses++;
    if (pix_valid) begin
      valid_seen++;
      frame_pix++;
    end
    if (frame_start) frame_fs++;
    if (chk_pix) begin
      exp_v = (pgx >= GX0) && (pgx < GX0 + H_ACTIVE) && (pgy >= GY0) && (pgy < GY0 + V_ACTIVE);
      checkOutput("pix_valid", 32'(pix_valid), 32'(exp_v));
      checkOutput("sync_err_quiet", 32'(sync_err), 32'd0);
      checkOutput("frame_start", 32'(frame_start), 32'(exp_v && pgx == GX0 && pgy == GY0));
      if (exp_v) begin
        checkOutput("pix_x", 32'(pix_x), 32'(pgx - GX0));
        checkOutput("pix_y", 32'(pix_y), 32'(pgy - GY0));
        checkOutput("pix_data", 32'(pix_data), 32'(pat(pgx, pgy)));
      end
    end
  endtask

  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      sample();
      if (!manual) begin
        h_sync   = hold_high ? 1'b1 : (gx >= HS_W);
        v_sync   = !(v_low(gx, gy) || (inj_v && gy == 10 && gx >= VS_X && gx < VS_X + 4));
        pixel_in = pat(gx, gy);
        pgx = gx;
        pgy = gy;
        gx++;
        if (gx >= line_len) begin
          gx = 0;
          gy = (gy + 1) % V_TOTAL;
          line_len = H_TOTAL;
        end
      end
    end
  endtask

  task automatic raw_step(input logic h, input logic v);
    @(negedge clk);
    sample();
    h_sync = h;
    v_sync = v;
  endtask

  // Run until the generator is about to drive column 0 of line y.
  task automatic goto_line(input int y);
    int n;
    n = 0;
    do begin
      applyStimulus(1);
      n++;
    end while (!(gx == 0 && gy == y) && n < 2 * FRAME);
  endtask

  task automatic wait_err(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      applyStimulus(1);
      if (sync_err) seen = 1'b1;
    end
  endtask

  task automatic checked_frame(input string tag);
    frame_pix = 0;
    frame_fs  = 0;
    chk_pix   = 1'b1;
    goto_line(0);
    chk_pix   = 1'b0;
    checkOutput({tag, "_pix_count"}, 32'(frame_pix), 32'(H_ACTIVE * V_ACTIVE));
    checkOutput({tag, "_fs_count"}, 32'(frame_fs), 32'd1);
  endtask

  initial begin
    compared = 0; mismatched = 0;
    gx = 0; gy = 0; line_len = H_TOTAL; pgx = -1; pgy = -1;
    err_pulses = 0; valid_seen = 0; frame_pix = 0; frame_fs = 0;
    hold_high = 0; inj_v = 0; manual = 0; chk_pix = 0;
    rst = 1'b1; h_sync = 1'b1; v_sync = 1'b1; pixel_in = '0;

    $display("[TB] reset state");
    goto_line(5);
    applyStimulus(10);
    checkOutput("rst_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("rst_pix_data", 32'(pix_data), 32'd0);
    checkOutput("rst_pix_x", 32'(pix_x), 32'd0);
    checkOutput("rst_pix_y", 32'(pix_y), 32'd0);
    checkOutput("rst_frame_start", 32'(frame_start), 32'd0);
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_sync_err", 32'(sync_err), 32'd0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;

    $display("[TB] nominal acquisition and locked frames");
    err_pulses = 0;
    goto_line(0);
    checkOutput("armed_not_locked", 32'(locked), 32'd0);
    goto_line(V_TOTAL - 1);
    checkOutput("tracking_not_locked", 32'(locked), 32'd0);
    goto_line(0);
    checkOutput("locked_after_frame", 32'(locked), 32'd1);
    checked_frame("frame2");
    checked_frame("frame3");
    checkOutput("nominal_no_err", 32'(err_pulses), 32'd0);
    checkOutput("nominal_err_cnt", 32'(err_cnt), 32'd0);

    $display("[TB] stretched line");
    goto_line(3);
    line_len = H_TOTAL + 1;
    wait_err(found);
    checkOutput("stretch_err_seen", 32'(found), 32'd1);
    checkOutput("stretch_err_col", 32'(obs_gx), 32'(H_TOTAL));
    checkOutput("stretch_err_line", 32'(obs_gy), 32'd3);
    checkOutput("stretch_err_cnt", 32'(err_cnt), 32'd1);
    checkOutput("stretch_unlocked", 32'(locked), 32'd0);
    applyStimulus(1);
    checkOutput("stretch_err_pulse_width", 32'(sync_err), 32'd0);
    goto_line(0);
    checkOutput("stretch_rearm_unlocked", 32'(locked), 32'd0);
    goto_line(0);
    checkOutput("stretch_relocked", 32'(locked), 32'd1);
    checkOutput("stretch_err_cnt_kept", 32'(err_cnt), 32'd1);

    $display("[TB] early v_sync");
    goto_line(10);
    inj_v = 1'b1;
    wait_err(found);
    inj_v = 1'b0;
    checkOutput("vearly_err_seen", 32'(found), 32'd1);
    checkOutput("vearly_err_col", 32'(obs_gx), 32'(VS_X));
    checkOutput("vearly_err_cnt", 32'(err_cnt), 32'd2);
    checkOutput("vearly_unlocked", 32'(locked), 32'd0);
    valid_seen = 0;
    goto_line(0);
    goto_line(0);
    checkOutput("vearly_no_pixels", 32'(valid_seen), 32'd0);
    checkOutput("vearly_relocked", 32'(locked), 32'd1);
    checked_frame("vearly_after");

    $display("[TB] reset mid-line while locked");
    goto_line(7);
    applyStimulus(15);
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    checkOutput("midrst_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("midrst_pix_data", 32'(pix_data), 32'd0);
    checkOutput("midrst_pix_x", 32'(pix_x), 32'd0);
    checkOutput("midrst_pix_y", 32'(pix_y), 32'd0);
    checkOutput("midrst_locked", 32'(locked), 32'd0);
    checkOutput("midrst_err_cnt", 32'(err_cnt), 32'd0);
    goto_line(0);
    checkOutput("midrst_one_vfall", 32'(locked), 32'd0);
    goto_line(0);
    checkOutput("midrst_two_vfalls", 32'(locked), 32'd1);
    checkOutput("midrst_err_cnt_after", 32'(err_cnt), 32'd0);

    $display("[TB] h_sync held high");
    rst = 1'b1;
    hold_high = 1'b1;
    applyStimulus(2);
    rst = 1'b0;
    err_pulses = 0;
    valid_seen = 0;
    goto_line(0);
    goto_line(0);
    goto_line(0);
    checkOutput("hold_locked", 32'(locked), 32'd0);
    checkOutput("hold_no_err", 32'(err_pulses), 32'd0);
    checkOutput("hold_no_pixels", 32'(valid_seen), 32'd0);
    checkOutput("hold_err_cnt", 32'(err_cnt), 32'd0);
    hold_high = 1'b0;

    $display("[TB] error counter saturation");
    manual = 1'b1;
    rst = 1'b1;
    raw_step(1'b1, 1'b1);
    raw_step(1'b1, 1'b1);
    rst = 1'b0;
    err_pulses = 0;
    for (int i = 0; i < 100; i++) begin
      raw_step(1'b1, 1'b0);
      raw_step(1'b0, 1'b0);
      raw_step(1'b1, 1'b0);
      raw_step(1'b0, 1'b1);
      raw_step(1'b1, 1'b1);
    end
    checkOutput("sat_cnt_100", 32'(err_cnt), 32'd100);
    for (int i = 0; i < 155; i++) begin
      raw_step(1'b1, 1'b0);
      raw_step(1'b0, 1'b0);
      raw_step(1'b1, 1'b0);
      raw_step(1'b0, 1'b1);
      raw_step(1'b1, 1'b1);
    end
    checkOutput("sat_cnt_255", 32'(err_cnt), 32'd255);
    for (int i = 0; i < 45; i++) begin
      raw_step(1'b1, 1'b0);
      raw_step(1'b0, 1'b0);
      raw_step(1'b1, 1'b0);
      raw_step(1'b0, 1'b1);
      raw_step(1'b1, 1'b1);
    end
    checkOutput("sat_cnt_300", 32'(err_cnt), 32'd255);
    checkOutput("sat_pulses", 32'(err_pulses), 32'd300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
